// File: rtl/dot_product_engine.sv
// Compute stage of the dot-product accelerator: streams packed signed elements
// from the A/B buffers through a two-stage multiply-accumulate pipeline.
module dot_product_engine #(
    parameter int ELEM_W = 8,
    parameter int LANES  = 4,
    parameter int ADDR_W = 10,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_compute,
    input  logic [31:0]       vector_len,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    input  logic [31:0]       rd_data_a,
    input  logic [31:0]       rd_data_b,
    output logic [ACC_W-1:0]  result,
    output logic              overflow,
    output logic              busy,
    output logic              processing_done
);

    // state | meaning
    // IDLE  | waiting for a rising edge of start_compute
    // READ  | one buffer word pair requested per cycle
    // DRAIN | last reads still flowing through the pipeline
    // DONE  | one-cycle completion pulse

    localparam int LANE_BITS = $clog2(LANES);
    localparam int LEN_W     = ADDR_W + LANE_BITS + 1;
    localparam int CNT_W     = ADDR_W + 1;
    localparam int PROD_W    = 2 * ELEM_W;
    localparam int SUM_W     = PROD_W + LANE_BITS;
    localparam int EXT_W     = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
    localparam logic [31:0] MAX_LEN = 32'(LANES) << ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                   state, state_next;
    logic                     start_prev;
    logic                     accept;
    logic [LEN_W-1:0]         len_c;
    logic [CNT_W-1:0]         n_words;
    logic [ADDR_W-1:0]        a_q, b_q, idx;
    logic [CNT_W-1:0]         words_left;
    logic [LEN_W-1:0]         elem_left;
    logic                     d_valid, s1_valid;
    logic [LANES-1:0]         d_mask;
    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0]  lane_sum, s1_sum;
    logic signed [EXT_W-1:0]  acc_ext;
    logic                     acc_ovf;

    assign accept  = (state == S_IDLE) && start_compute && !start_prev;
    assign len_c   = (vector_len > MAX_LEN) ? LEN_W'(MAX_LEN) : vector_len[LEN_W-1:0];
    assign n_words = CNT_W'((len_c + LEN_W'(LANES - 1)) >> LANE_BITS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            start_prev <= 1'b0;
        end else begin
            state      <= state_next;
            start_prev <= start_compute;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = (len_c == '0) ? S_DONE : S_READ;
            S_READ:  if (words_left == CNT_W'(1)) state_next = S_DRAIN;
            S_DRAIN: if (!d_valid) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        rd_en           = (state == S_READ);
        busy            = (state != S_IDLE);
        processing_done = (state == S_DONE);
        rd_addr_a       = a_q + idx;
        rd_addr_b       = b_q + idx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q        <= '0;
            b_q        <= '0;
            idx        <= '0;
            words_left <= '0;
            elem_left  <= '0;
            result     <= '0;
            overflow   <= 1'b0;
        end else if (accept) begin
            a_q        <= a_base;
            b_q        <= b_base;
            idx        <= '0;
            words_left <= n_words;
            elem_left  <= len_c;
            result     <= '0;
            overflow   <= 1'b0;
        end else begin
            if (state == S_READ) begin
                idx        <= idx + ADDR_W'(1);
                words_left <= words_left - CNT_W'(1);
                elem_left  <= (elem_left >= LEN_W'(LANES)) ? elem_left - LEN_W'(LANES) : '0;
            end
            if (s1_valid) begin
                result   <= acc_ext[ACC_W-1:0];
                overflow <= overflow | acc_ovf;
            end
        end
    end

    // The lane mask travels with the read so the tail word ignores stale lanes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_valid  <= 1'b0;
            d_mask   <= '0;
            s1_valid <= 1'b0;
            s1_sum   <= '0;
        end else begin
            d_valid <= rd_en;
            for (int k = 0; k < LANES; k++) begin
                d_mask[k] <= rd_en && (elem_left > LEN_W'(k));
            end
            s1_valid <= d_valid;
            s1_sum   <= lane_sum;
        end
    end

    always_comb begin
        prod     = '0;
        lane_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            prod = $signed(rd_data_a[ELEM_W*k +: ELEM_W]) * $signed(rd_data_b[ELEM_W*k +: ELEM_W]);
            if (d_mask[k]) lane_sum = lane_sum + SUM_W'(prod);
        end
    end

    // Add in a width that cannot itself overflow, then check it fits ACC_W.
    always_comb begin
        acc_ext = EXT_W'($signed(result)) + EXT_W'(s1_sum);
        acc_ovf = (acc_ext != EXT_W'($signed(acc_ext[ACC_W-1:0])));
    end

endmodule
